spi_cmd_driver: RTL and testbench

// - Parametrised SPI mode-0 master that issues register read/write frames to the onboarding SPI peripheral.
// - Commands are buffered in a FIFO and replayed autonomously.
// - Drives the peripheral SPI pins: SCLK, COPI, nCS map to ui_in[0], ui_in[1], ui_in[2] of the onboarding top; CIPO is the read-data return pin.
// - Used in the bench harness and as an on-chip self-test stimulus source.

---
 rtl/spi_drv_pkg.sv | 15 +
 rtl/spi_cmd_driver_if.sv | 26 ++
 rtl/sync_fifo.sv | 42 ++++
 rtl/spi_cmd_driver.sv | 154 +++++++++++++++
 tb/tb_spi_cmd_driver.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_drv_pkg.sv
// rtl/spi_drv_pkg.sv - shared types, defaults and frame-width helper for the SPI command driver
package spi_drv_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_cmd_driver_if.sv
// rtl/spi_cmd_driver_if.sv - command push and response bus of the SPI command driver
interface spi_cmd_driver_if
  import spi_drv_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready, busy, done, rsp_data
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - pointer+count synchronous FIFO; refuses push when full, pop when empty
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/spi_cmd_driver.sv
// rtl/spi_cmd_driver.sv - SPI mode-0 master replaying buffered {rw,addr,data} frames
module spi_cmd_driver
  import spi_drv_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  spi_cmd_driver_if.slave cmd,
  output logic            sclk,
  output logic            copi,
  output logic            ncs,
  input  logic            cipo
);
  localparam int FW    = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W   = $clog2(2 * FW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(2 * FW - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [H_W-1:0]    h_q, h_d, h_nxt;
  logic [FW-1:0]     tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d, rsp_q, rsp_d;
  logic              sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d, done_q, done_d;
  logic              fifo_full, fifo_empty, fifo_pop, half_end, start;
  logic [FW-1:0]     fifo_dout;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .pop   (fifo_pop),
    .din   ({cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pin values are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rsp_d    = rsp_q;
    sclk_d   = sclk_q;
    copi_d   = copi_q;
    ncs_d    = ncs_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    start    = 1'b0;
    h_nxt    = h_q + 1'b1;
    half_end = (cnt_q == CNT_LAST);
    if (state_q != IDLE) cnt_d = half_end ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        start  = !fifo_empty;
      end
      SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          h_d     = '0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (h_q == H_LAST) begin
            state_d = HOLD;
            sclk_d  = 1'b0;
          end else begin
            h_d    = h_nxt;
            sclk_d = h_nxt[0];
            if (h_nxt[0]) begin
              rx_d = {rx_q[DATA_W-2:0], cipo};
            end else begin
              tx_d   = tx_q << 1;
              copi_d = tx_q[FW-2];
            end
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d = GAP;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          rsp_d   = rx_q;
        end
      end
      GAP: begin
        if (half_end) begin
          if (!fifo_empty) start = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Back-to-back frames reload straight from GAP without passing through IDLE.
    if (start) begin
      fifo_pop = 1'b1;
      tx_d     = fifo_dout;
      state_d  = SETUP;
      cnt_d    = '0;
      ncs_d    = 1'b0;
      sclk_d   = 1'b0;
      copi_d   = fifo_dout[FW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
    end
  end

  assign sclk          = sclk_q;
  assign copi          = copi_q;
  assign ncs           = ncs_q;
  assign cmd.cmd_ready = !fifo_full;
  assign cmd.busy      = (state_q != IDLE) || !fifo_empty;
  assign cmd.done      = done_q;
  assign cmd.rsp_data  = rsp_q;
endmodule

// File: tb/tb_spi_cmd_driver.sv
// tb/tb_spi_cmd_driver.sv - self-checking bench for spi_cmd_driver
module tb_spi_cmd_driver;
  import spi_drv_pkg::*;

  localparam int D     = 2;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FW    = frame_w(AW, DW);
  localparam int FL    = (2 * FW + 3) * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, copi, ncs;
  logic cipo = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  bit   sweep_go = 0;

  spi_cmd_driver_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_cmd_driver #(.CLK_DIV(D), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus),
    .sclk (sclk),
    .copi (copi),
    .ncs  (ncs),
    .cipo (cipo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of pending commands and the cycle offset into the current frame.
  logic [FW-1:0] mq[$];
  logic [FW-1:0] m_cur = '0;
  logic [DW-1:0] m_rx = '0;
  logic [DW-1:0] m_rsp = '0;
  int            m_t = -1;
  logic [FW-1:0] periph_word = '0;

  always @(posedge clk) begin
    bit was_full;
    int half;
    if (rst) begin
      mq.delete();
      m_t   = -1;
      m_rx  = '0;
      m_rsp = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (m_t >= 0) begin
        m_t++;
        half = m_t / D;
        if (m_t % D == 0 && half >= 2 && half <= 2 * FW && half % 2 == 0)
          m_rx = {m_rx[DW-2:0], cipo};
        if (m_t == (2 * FW + 2) * D) m_rsp = m_rx;
        if (m_t == FL) m_t = -1;
      end
      if (m_t < 0 && mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_t   = 0;
      end
      if (bus.cmd_valid && !was_full) mq.push_back({bus.cmd_rw, bus.cmd_addr, bus.cmd_data});
    end
  end

  // Peripheral: presents bit j of periph_word while SCLK is low ahead of the j-th rising edge.
  always @(negedge clk) begin
    int j;
    if (m_t >= 0) begin
      j = (m_t / D == 0) ? 0 : (m_t / D - 1) / 2;
      if (j > FW - 1) j = FW - 1;
      cipo = periph_word[FW-1-j];
    end else begin
      cipo = 1'b0;
    end
  end

  always @(negedge clk) begin
    int   half;
    logic e_ncs, e_sclk, e_copi, e_done;
    bit   ck_copi;
    if (chk_en) begin
      e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_done = 1'b0; ck_copi = 0;
      if (m_t >= 0) begin
        half = m_t / D;
        if (half == 0) begin
          e_ncs = 1'b0; e_copi = m_cur[FW-1]; ck_copi = 1;
        end else if (half <= 2 * FW) begin
          e_ncs = 1'b0; e_sclk = ((half - 1) % 2) == 1;
          e_copi = m_cur[FW-1-(half-1)/2]; ck_copi = 1;
        end else if (half == 2 * FW + 1) begin
          e_ncs = 1'b0; e_copi = m_cur[0]; ck_copi = 1;
        end else begin
          e_done = (m_t == (2 * FW + 2) * D);
        end
      end
      chk("ncs", ncs, e_ncs);
      chk("sclk", sclk, e_sclk);
      if (ck_copi) chk("copi", copi, e_copi);
      chk("done", bus.done, e_done);
      chk("cmd_ready", bus.cmd_ready, mq.size() < DEPTH);
      chk("busy", bus.busy, (m_t >= 0) || (mq.size() != 0));
      chk("rsp_data", bus.rsp_data, m_rsp);
    end
  end

  // Pin monitor: frame words as seen on the wire and ncs-high gaps between frames.
  logic [FW-1:0] cap_q[$];
  int            gap_q[$];
  logic [FW-1:0] mon_word = '0;
  logic          mon_ps = 1'b0, mon_pn = 1'b1;
  int            cyc = 0, rise_at = 0, done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (ncs === 1'b0 && !mon_ps && sclk) mon_word = {mon_word[FW-2:0], copi};
    if (!mon_pn && ncs === 1'b1) begin
      cap_q.push_back(mon_word);
      mon_word = '0;
      rise_at  = cyc;
    end
    if (mon_pn && ncs === 1'b0) gap_q.push_back(cyc - rise_at);
    if (bus.done === 1'b1) done_cnt++;
    mon_ps = sclk;
    mon_pn = ncs;
  end

  // Push one command on an idle driver; cycle 1 is the cycle after the push edge.
  task automatic run_frame(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [FW-1:0] word, output int done_at, output int low,
                           output int rises, output logic [DW-1:0] rsp, output int nd);
    logic ps;
    bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_addr = a; bus.cmd_data = d;
    word = '0; done_at = -1; low = 0; rises = 0; rsp = '0; nd = 0; ps = sclk;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (!ncs) low++;
      if (!ps && sclk) begin
        rises++;
        word = {word[FW-2:0], copi};
      end
      ps = sclk;
      if (bus.done) begin
        nd++;
        done_at = n;
        rsp = bus.rsp_data;
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SD = (g == 0) ? 1 : 3;
    spi_cmd_driver_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();
    logic s_sclk, s_copi, s_ncs;
    bit   fin = 0;

    spi_cmd_driver #(.CLK_DIV(SD), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .cmd  (sif),
      .sclk (s_sclk),
      .copi (s_copi),
      .ncs  (s_ncs),
      .cipo (1'b0)
    );

    initial begin
      int fall_at, rise1, rise2, nrise, low, idle_at, nd;
      logic ps;
      logic [FW-1:0] word;
      logic [DW-1:0] rsp;
      sif.cmd_valid = 1'b0; sif.cmd_rw = 1'b0; sif.cmd_addr = '0; sif.cmd_data = '0;
      for (int n = 0; n < 1000 && !sweep_go; n++) @(negedge clk);
      sif.cmd_valid = 1'b1; sif.cmd_rw = 1'b1; sif.cmd_addr = 7'h15; sif.cmd_data = 8'h3C;
      @(negedge clk);
      sif.cmd_valid = 1'b0;
      fall_at = -1; rise1 = -1; rise2 = -1; nrise = 0; low = 0; idle_at = -1; nd = 0;
      ps = 1'b0; word = '0; rsp = 'x;
      for (int n = 1; n <= 200 * SD && idle_at < 0; n++) begin
        if (fall_at < 0 && !s_ncs) fall_at = n;
        if (!s_ncs) low++;
        if (!ps && s_sclk) begin
          nrise++;
          word = {word[FW-2:0], s_copi};
          if (nrise == 1) rise1 = n;
          if (nrise == 2) rise2 = n;
        end
        ps = s_sclk;
        if (sif.done) begin
          nd++;
          rsp = sif.rsp_data;
        end
        if (fall_at >= 0 && !sif.busy) idle_at = n;
        @(negedge clk);
      end
      chk($sformatf("sweep%0d_sclk_period", SD), rise2 - rise1, 2 * SD);
      chk($sformatf("sweep%0d_ncs_low", SD), low, 34 * SD);
      chk($sformatf("sweep%0d_frame_len", SD), idle_at - fall_at, 35 * SD);
      chk($sformatf("sweep%0d_done_count", SD), nd, 1);
      chk($sformatf("sweep%0d_copi_word", SD), word, 16'h953C);
      chk($sformatf("sweep%0d_rsp", SD), rsp, 8'h00);
      fin = 1;
    end
  end

  initial begin
    logic [FW-1:0] word;
    logic [DW-1:0] rsp;
    int            done_at, low, rises, nd;
    logic          ps, acc;
    logic [FW-1:0] burst[5];

    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);
    chk("rst_ncs", ncs, 1);
    rst = 1'b0;
    sweep_go = 1;
    @(negedge clk);

    periph_word = 16'h5A3C;
    run_frame(1'b1, 7'h00, 8'hFF, word, done_at, low, rises, rsp, nd);
    chk("wr_copi_word", word, 16'h80FF);
    chk("wr_done_cycle", done_at, 70);
    chk("wr_ncs_low", low, 68);
    chk("wr_sclk_rises", rises, 16);
    chk("wr_done_count", nd, 1);

    periph_word = 16'h00A5;
    run_frame(1'b0, 7'h04, 8'h00, word, done_at, low, rises, rsp, nd);
    chk("rd_copi_word", word, 16'h0400);
    chk("rd_rsp_data", rsp, 8'hA5);
    chk("rd_done_cycle", done_at, 70);

    periph_word = 16'h1234;
    burst = '{16'h8155, 16'h0AC3, 16'hFE01, 16'h7F7F, 16'h9234};
    cap_q.delete();
    gap_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      {bus.cmd_rw, bus.cmd_addr, bus.cmd_data} = burst[i];
      acc = 1'b0;
      for (int w = 0; w < 200 && !acc; w++) begin
        acc = bus.cmd_ready;
        @(negedge clk);
      end
      chk($sformatf("burst_push%0d_accepted", i), acc, 1);
    end
    bus.cmd_valid = 1'b0;
    for (int w = 0; w < 800 && (cap_q.size() < 5 || bus.busy); w++) @(negedge clk);
    chk("burst_frame_count", cap_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < cap_q.size()) chk($sformatf("burst_frame%0d", i), cap_q[i], burst[i]);
    for (int i = 1; i < 5; i++)
      if (i < gap_q.size()) chk($sformatf("burst_gap%0d", i), gap_q[i], D);
    chk("burst_done_count", done_cnt, 5);

    periph_word = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1;
      {bus.cmd_rw, bus.cmd_addr, bus.cmd_data} = 16'hC000 | 16'(i);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    rises = 0;
    ps = sclk;
    for (int n = 0; n < 200 && rises < 5; n++) begin
      @(negedge clk);
      if (!ps && sclk) rises++;
      ps = sclk;
    end
    chk("abort_reached_h9", rises, 5);
    rst = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    chk("abort_ncs", ncs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_done", bus.done, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_ncs_idle", ncs, 1);
    run_frame(1'b1, 7'h2A, 8'h5C, word, done_at, low, rises, rsp, nd);
    chk("post_abort_copi_word", word, 16'hAA5C);
    chk("post_abort_done_cycle", done_at, 70);
    chk("post_abort_ncs_low", low, 68);

    for (int n = 0; n < 2000 && !(g_sweep[0].fin && g_sweep[1].fin); n++) @(negedge clk);
    chk("sweep_complete", {g_sweep[1].fin, g_sweep[0].fin}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
